nms_stage: RTL and testbench

- Canny non-maximum suppression stage, directly downstream of the Sobel gradient stage.
- Consumes the raster-order 14-bit {grad_val[11:0], grad_dir[1:0]} pixel stream.
- Builds a 3x3 window of gradient words using two internal line buffers.
- Emits a thinned 12-bit magnitude per pixel, in raster order, to the double-threshold stage.

---
 rtl/canny_pkg.sv | 17 +
 rtl/nms_stage_if.sv | 24 ++
 rtl/nms_line_buf.sv | 25 ++
 rtl/nms_stage.sv | 200 ++++++++++++++++++++
 tb/tb_nms_stage.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/canny_pkg.sv
// Shared definitions for the Canny edge pipeline stages.
package canny_pkg;

    localparam int unsigned VAL_W = 12;

    localparam logic [1:0] DIR_0   = 2'b00;
    localparam logic [1:0] DIR_45  = 2'b01;
    localparam logic [1:0] DIR_90  = 2'b10;
    localparam logic [1:0] DIR_135 = 2'b11;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StFlush = 2'b10
    } nms_state_e;

endpackage

// File: rtl/nms_stage_if.sv
// Pixel-stream handshake between the Sobel stage, this stage and the threshold stage.
interface nms_stage_if #(
    parameter int unsigned VAL_W = canny_pkg::VAL_W
);
    logic             in_valid;
    logic             in_sof;
    logic [VAL_W+1:0] in_val_dir;
    logic             in_ready;
    logic             out_valid;
    logic             out_sof;
    logic             out_eof;
    logic [VAL_W-1:0] out_val;
    logic             err_flag;

    modport master (
        output in_valid, in_sof, in_val_dir,
        input  in_ready, out_valid, out_sof, out_eof, out_val, err_flag
    );

    modport slave (
        input  in_valid, in_sof, in_val_dir,
        output in_ready, out_valid, out_sof, out_eof, out_val, err_flag
    );
endinterface

// File: rtl/nms_line_buf.sv
// One-line delay RAM: simple dual port, read-first, one-cycle registered read.
module nms_line_buf #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WIDTH = 14,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Non-blocking read and write in one block gives old data on an address collision.
    always_ff @(posedge clk) begin
        if (re_i) rdata_q <= mem_q[raddr_i];
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/nms_stage.sv
// Canny non-maximum suppression: 3x3 window over the gradient stream, thinned magnitude out.
module nms_stage #(
    parameter int unsigned IMG_W = 1024,
    parameter int unsigned IMG_H = 768,
    parameter int unsigned VAL_W = canny_pkg::VAL_W
) (
    input logic        clk,
    input logic        rst_n,
    nms_stage_if.slave io
);
    import canny_pkg::*;

    localparam int unsigned DW = VAL_W + 2;
    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H + 2);

    nms_state_e state_q, state_d;
    logic [CW-1:0] col_q, col_d, pix_col;
    logic [RW-1:0] row_q, row_d, pix_row;
    logic          err_q, err_d;
    logic          in_ready, acc, pix_v;
    logic [DW-1:0] pix_data;

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        err_d    = err_q;
        pix_v    = 1'b0;
        pix_col  = col_q;
        pix_row  = row_q;
        pix_data = io.in_val_dir;
        in_ready = (state_q != StFlush);
        acc      = io.in_valid && in_ready;
        if (state_q == StFlush) begin
            pix_v    = 1'b1;
            pix_data = '0;
            err_d    = err_q | io.in_valid;
        end else if (acc) begin
            if (io.in_sof) begin
                pix_v   = 1'b1;
                pix_col = '0;
                pix_row = '0;
                err_d   = err_q | (state_q == StRun);
                state_d = StRun;
            end else if (state_q == StRun) begin
                pix_v = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
        // Advance the raster position of whatever pixel entered the pipe this cycle.
        if (pix_v) begin
            if (pix_col == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = pix_row + RW'(1);
                if (state_q == StRun && pix_row == RW'(IMG_H - 1)) state_d = StFlush;
            end else begin
                col_d = pix_col + CW'(1);
                row_d = pix_row;
            end
            if (state_q == StFlush && pix_row == RW'(IMG_H + 1)) begin
                state_d = StIdle;
                col_d   = '0;
                row_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            col_q   <= '0;
            row_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            err_q   <= err_d;
        end
    end

    logic          v1_q;
    logic [CW-1:0] col1_q;
    logic [RW-1:0] row1_q;
    logic [DW-1:0] cur1_q, up1, up2;

    nms_line_buf #(.DEPTH(IMG_W), .WIDTH(DW)) u_buf0 (
        .clk     (clk),
        .we_i    (pix_v),
        .waddr_i (pix_col),
        .wdata_i (pix_data),
        .re_i    (pix_v),
        .raddr_i (pix_col),
        .rdata_o (up1)
    );

    // Second line is written one cycle late from buf0's registered read data.
    nms_line_buf #(.DEPTH(IMG_W), .WIDTH(DW)) u_buf1 (
        .clk     (clk),
        .we_i    (v1_q),
        .waddr_i (col1_q),
        .wdata_i (up1),
        .re_i    (pix_v),
        .raddr_i (pix_col),
        .rdata_o (up2)
    );

    logic [CW-1:0] cc;
    logic [RW-1:0] cr;
    logic          emit;

    always_comb begin
        if (col1_q == '0) begin
            cc = CW'(IMG_W - 1);
            cr = row1_q - RW'(2);
        end else begin
            cc = col1_q - CW'(1);
            cr = row1_q - RW'(1);
        end
        emit = (row1_q >= RW'(2)) || (row1_q == RW'(1) && col1_q != '0);
    end

    logic [2:0][2:0][DW-1:0] win_q;
    logic                    v2_q, bord2_q, sof2_q, eof2_q;
    logic [VAL_W-1:0]        c_mag, n1, n2;

    always_comb begin
        c_mag = win_q[1][1][DW-1:2];
        n1    = win_q[1][0][DW-1:2];
        n2    = win_q[1][2][DW-1:2];
        unique case (win_q[1][1][1:0])
            DIR_0:   begin n1 = win_q[1][0][DW-1:2]; n2 = win_q[1][2][DW-1:2]; end
            DIR_90:  begin n1 = win_q[0][1][DW-1:2]; n2 = win_q[2][1][DW-1:2]; end
            DIR_45:  begin n1 = win_q[0][2][DW-1:2]; n2 = win_q[2][0][DW-1:2]; end
            DIR_135: begin n1 = win_q[0][0][DW-1:2]; n2 = win_q[2][2][DW-1:2]; end
            default: ;
        endcase
    end

    logic             v3_q, sof3_q, eof3_q, out_valid_q, out_sof_q, out_eof_q;
    logic [VAL_W-1:0] val3_q, out_val_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            col1_q      <= '0;
            row1_q      <= '0;
            cur1_q      <= '0;
            win_q       <= '0;
            v2_q        <= 1'b0;
            bord2_q     <= 1'b0;
            sof2_q      <= 1'b0;
            eof2_q      <= 1'b0;
            v3_q        <= 1'b0;
            sof3_q      <= 1'b0;
            eof3_q      <= 1'b0;
            val3_q      <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            out_val_q   <= '0;
        end else begin
            v1_q   <= pix_v;
            col1_q <= pix_col;
            row1_q <= pix_row;
            cur1_q <= pix_data;
            v2_q   <= v1_q && emit;
            if (v1_q) begin
                for (int i = 0; i < 3; i++) begin
                    win_q[i][0] <= win_q[i][1];
                    win_q[i][1] <= win_q[i][2];
                end
                win_q[0][2] <= up2;
                win_q[1][2] <= up1;
                win_q[2][2] <= cur1_q;
                bord2_q <= (cr == '0) || (cr == RW'(IMG_H - 1)) ||
                           (cc == '0) || (cc == CW'(IMG_W - 1));
                sof2_q  <= (cr == '0) && (cc == '0);
                eof2_q  <= (cr == RW'(IMG_H - 1)) && (cc == CW'(IMG_W - 1));
            end
            v3_q   <= v2_q;
            sof3_q <= v2_q && sof2_q;
            eof3_q <= v2_q && eof2_q;
            val3_q <= (v2_q && !bord2_q && c_mag >= n1 && c_mag > n2) ? c_mag : '0;
            out_valid_q <= v3_q;
            out_sof_q   <= sof3_q;
            out_eof_q   <= eof3_q;
            out_val_q   <= v3_q ? val3_q : '0;
        end
    end

    assign io.in_ready  = in_ready;
    assign io.out_valid = out_valid_q;
    assign io.out_sof   = out_sof_q;
    assign io.out_eof   = out_eof_q;
    assign io.out_val   = out_val_q;
    assign io.err_flag  = err_q;
endmodule

// File: tb/tb_nms_stage.sv
// Directed bench for nms_stage: image model feeds an expected-output queue, monitor pops and compares.
module tb_nms_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        tb_valid, tb_sof, sel;
    logic [13:0] tb_data;

    always #5 clk = ~clk;

    nms_stage_if #(.VAL_W(12)) ifa ();
    nms_stage_if #(.VAL_W(12)) ifb ();

    assign ifa.in_valid   = tb_valid & ~sel;
    assign ifa.in_sof     = tb_sof;
    assign ifa.in_val_dir = tb_data;
    assign ifb.in_valid   = tb_valid & sel;
    assign ifb.in_sof     = tb_sof;
    assign ifb.in_val_dir = tb_data;

    nms_stage #(.IMG_W(5), .IMG_H(4), .VAL_W(12)) dut_a (.clk(clk), .rst_n(rst_n), .io(ifa));
    nms_stage #(.IMG_W(5), .IMG_H(5), .VAL_W(12)) dut_b (.clk(clk), .rst_n(rst_n), .io(ifb));

    logic        mon_valid, mon_sof, mon_eof, mon_err, rdy;
    logic [11:0] mon_val;
    assign mon_valid = sel ? ifb.out_valid : ifa.out_valid;
    assign mon_sof   = sel ? ifb.out_sof   : ifa.out_sof;
    assign mon_eof   = sel ? ifb.out_eof   : ifa.out_eof;
    assign mon_val   = sel ? ifb.out_val   : ifa.out_val;
    assign mon_err   = sel ? ifb.err_flag  : ifa.err_flag;
    assign rdy       = sel ? ifb.in_ready  : ifa.in_ready;

    typedef struct packed {
        logic [11:0] v;
        logic        s;
        logic        e;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    int          n_out = 0;
    int          cur_w, cur_h;
    logic [13:0] img [0:4][0:4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] model(input int r, input int c);
        int          dr1, dc1, dr2, dc2;
        logic [11:0] cm, n1, n2;
        logic [13:0] px;
        if (r == 0 || r == cur_h - 1 || c == 0 || c == cur_w - 1) return 12'd0;
        px = img[r][c];
        cm = px[13:2];
        case (px[1:0])
            2'b00:   begin dr1 = 0;  dc1 = -1; dr2 = 0; dc2 = 1;  end
            2'b10:   begin dr1 = -1; dc1 = 0;  dr2 = 1; dc2 = 0;  end
            2'b01:   begin dr1 = -1; dc1 = 1;  dr2 = 1; dc2 = -1; end
            default: begin dr1 = -1; dc1 = -1; dr2 = 1; dc2 = 1;  end
        endcase
        px = img[r+dr1][c+dc1];
        n1 = px[13:2];
        px = img[r+dr2][c+dc2];
        n2 = px[13:2];
        return (cm >= n1 && cm > n2) ? cm : 12'd0;
    endfunction

    // kind: 0 flat, 1 column 2, 2 anti-diagonal, 3 main diagonal
    task automatic fill(input int w, input int h, input int kind, input logic [13:0] fg,
                        input logic [13:0] bg);
        cur_w = w;
        cur_h = h;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                img[r][c] = ((kind == 1 && c == 2) || (kind == 2 && c == w - 1 - r) ||
                             (kind == 3 && r == c)) ? fg : bg;
    endtask

    task automatic push_frame();
        for (int r = 0; r < cur_h; r++)
            for (int c = 0; c < cur_w; c++)
                sb.push_back('{v: model(r, c), s: (r == 0 && c == 0),
                               e: (r == cur_h - 1 && c == cur_w - 1)});
    endtask

    task automatic send_pix(input logic [13:0] d, input logic s);
        int n = 0;
        while (!rdy && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!rdy) check("ready_timeout", 0, 1);
        tb_valid = 1'b1;
        tb_sof   = s;
        tb_data  = d;
        @(posedge clk);
        #1;
        tb_valid = 1'b0;
        tb_sof   = 1'b0;
    endtask

    task automatic drive_frame(input bit lat);
        for (int r = 0; r < cur_h; r++)
            for (int c = 0; c < cur_w; c++) begin
                if (lat && r == 2 && c == 1) begin
                    repeat (6) @(posedge clk);
                    #1;
                    send_pix(img[r][c], 1'b0);
                    @(posedge clk); #1; check("lat_edge1", mon_valid, 0);
                    @(posedge clk); #1; check("lat_edge2", mon_valid, 0);
                    @(posedge clk); #1; check("lat_edge3", mon_valid, 1);
                end else begin
                    send_pix(img[r][c], r == 0 && c == 0);
                end
            end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        repeat (5) @(posedge clk);
        #1;
        check("drain_left", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (mon_valid) begin
            if (sb.size() == 0) begin
                check("extra_out", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("out_val", mon_val, mon_e.v);
                check("out_sof", mon_sof, mon_e.s);
                check("out_eof", mon_eof, mon_e.e);
            end
            n_out++;
        end else begin
            check("idle_val", mon_val, 0);
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n0, n;
        rst_n    = 1'b0;
        tb_valid = 1'b0;
        tb_sof   = 1'b0;
        tb_data  = '0;
        sel      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", mon_valid, 0);
        check("rst_val", mon_val, 0);
        check("rst_sof", mon_sof, 0);
        check("rst_eof", mon_eof, 0);
        check("rst_err", mon_err, 0);
        check("rst_ready", rdy, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Vertical ridge
        fill(5, 4, 1, {12'd200, 2'b00}, {12'd50, 2'b00});
        n0 = n_out;
        push_frame();
        drive_frame(0);
        drain();
        check("ridge_count", n_out - n0, 20);
        check("ridge_err", mon_err, 0);

        // Flat field plus flush length
        fill(5, 4, 0, {12'd100, 2'b00}, {12'd100, 2'b00});
        n0 = n_out;
        push_frame();
        drive_frame(0);
        n = 0;
        while (!rdy && n < 50) begin
            n++;
            @(posedge clk);
            #1;
        end
        check("flush_len", n, 6);
        drain();
        check("flat_count", n_out - n0, 20);

        // Isolated accept of pixel (2,1)
        fill(5, 4, 1, {12'd200, 2'b00}, {12'd50, 2'b00});
        push_frame();
        drive_frame(1);
        drain();

        // Diagonal ridges on the 5x5 instance
        sel = 1'b1;
        fill(5, 5, 2, {12'd300, 2'b01}, {12'd10, 2'b01});
        push_frame();
        drive_frame(0);
        drain();
        fill(5, 5, 3, {12'd300, 2'b11}, {12'd10, 2'b11});
        push_frame();
        drive_frame(0);
        drain();
        fill(5, 5, 2, {12'd300, 2'b11}, {12'd10, 2'b11});
        check("diag_model_c", model(2, 2), 300);
        n0 = n_out;
        push_frame();
        drive_frame(0);
        check("diag_err_pre", mon_err, 0);
        tb_valid = 1'b1;
        tb_data  = {12'd999, 2'b00};
        repeat (2) @(posedge clk);
        #1;
        tb_valid = 1'b0;
        drain();
        check("flush_drop_err", mon_err, 1);
        check("flush_drop_count", n_out - n0, 25);

        // Start of frame mid-frame
        sel = 1'b0;
        #1;
        check("sof_err_pre", mon_err, 0);
        fill(5, 4, 1, {12'd200, 2'b00}, {12'd50, 2'b00});
        n0 = n_out;
        sb.push_back('{v: 12'd0, s: 1'b1, e: 1'b0});
        push_frame();
        for (int i = 0; i < 7; i++) send_pix(img[i / 5][i % 5], i == 0);
        drive_frame(0);
        check("sof_restart_err", mon_err, 1);
        drain();
        check("sof_restart_count", n_out - n0, 21);

        // Reset mid-frame
        for (int i = 0; i < 4; i++) send_pix(img[i / 5][i % 5], i == 0);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", mon_valid, 0);
        check("midrst_val", mon_val, 0);
        check("midrst_err", mon_err, 0);
        check("midrst_ready", rdy, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n0 = n_out;
        push_frame();
        drive_frame(0);
        drain();
        check("post_rst_count", n_out - n0, 20);
        check("post_rst_err", mon_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
